csr_bank_param: RTL and testbench

Parametrised successor of the core CSR file. It holds N approximation-control registers (ALU/MUL/DIV and further units) and full RISC-V CSR read-modify-write semantics (RW/RS/RC). It also holds 64-bit mcycle/minstret, a configurable number of hardware performance-monitor counters, and mcountinhibit. It sits beside the execute stage; the approximation registers fan out to the approximate arithmetic units.

---
 rtl/csr_bank_param.sv | 141 ++++++++++++++
 tb/tb_csr_bank_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_bank_param.sv
// csr_bank_param: approximation-control CSRs, 64-bit counters and mcountinhibit.
// Optional macro CSR_USER_COUNTERS_EN maps read-only user counter shadows (C-range).
module csr_bank_param #(
    parameter int          NUM_APX  = 3,
    parameter logic [11:0] APX_BASE = 12'h800,
    parameter int          NUM_HPM  = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 csr_valid,
    input  logic [1:0]                           csr_op,
    input  logic [11:0]                          csr_index,
    input  logic [31:0]                          csr_wdata,
    output logic [31:0]                          csr_rdata,
    output logic                                 csr_illegal,
    input  logic                                 instr_retire,
    input  logic [(NUM_HPM>0?NUM_HPM:1)-1:0]     hpm_event,
    output logic [32*NUM_APX-1:0]                apx_csr_flat
);

    // counter slots: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i)
    localparam int NC = 2 + NUM_HPM;
    localparam logic [31:0] INH_MASK =
        32'(64'h5 | (((64'h1 << NUM_HPM) - 64'h1) << 3));

    logic [31:0] apx_q [NUM_APX];
    logic [31:0] apx_d [NUM_APX];
    logic [63:0] cnt_q [NC];
    logic [63:0] cnt_d [NC];
    logic [31:0] inh_q;
    logic [31:0] inh_d;

    logic [NUM_APX-1:0] apx_hit;
    logic [NC-1:0]      lo_hit;
    logic [NC-1:0]      hi_hit;
    logic [NC-1:0]      ulo_hit;
    logic [NC-1:0]      uhi_hit;
    logic [NC-1:0]      inc;
    logic               inh_hit;
    logic               hit;
    logic               ro;
    logic               wr_req;
    logic               do_wr;
    logic [31:0]        rd;
    logic [31:0]        wval;

    function automatic logic [11:0] cnt_off(input int k);
        return (k == 0) ? 12'd0 : 12'(k + 1);
    endfunction

    // address decode and old-value read mux
    always_comb begin
        apx_hit = '0;
        lo_hit  = '0;
        hi_hit  = '0;
        ulo_hit = '0;
        uhi_hit = '0;
        rd      = '0;
        inh_hit = (csr_index == 12'h320);
        for (int i = 0; i < NUM_APX; i++) begin
            apx_hit[i] = (csr_index == APX_BASE + 12'(i));
            rd = rd | (apx_hit[i] ? apx_q[i] : 32'd0);
        end
        for (int k = 0; k < NC; k++) begin
            lo_hit[k] = (csr_index == 12'hB00 + cnt_off(k));
            hi_hit[k] = (csr_index == 12'hB80 + cnt_off(k));
`ifdef CSR_USER_COUNTERS_EN
            ulo_hit[k] = (csr_index == 12'hC00 + cnt_off(k));
            uhi_hit[k] = (csr_index == 12'hC80 + cnt_off(k));
`else
            ulo_hit[k] = 1'b0;
            uhi_hit[k] = 1'b0;
`endif
            rd = rd | ((lo_hit[k] | ulo_hit[k]) ? cnt_q[k][31:0] : 32'd0);
            rd = rd | ((hi_hit[k] | uhi_hit[k]) ? cnt_q[k][63:32] : 32'd0);
        end
        rd  = rd | (inh_hit ? inh_q : 32'd0);
        ro  = (|ulo_hit) | (|uhi_hit);
        hit = (|apx_hit) | (|lo_hit) | (|hi_hit) | inh_hit | ro;
    end

    // read-modify-write value and legality; RS/RC with zero mask is a pure read
    always_comb begin
        wval = csr_wdata;
        unique case (csr_op)
            2'b10:   wval = rd | csr_wdata;
            2'b11:   wval = rd & ~csr_wdata;
            default: wval = csr_wdata;
        endcase
        wr_req      = (csr_op != 2'b00) && !(csr_op[1] && (csr_wdata == 32'd0));
        do_wr       = csr_valid & wr_req & hit & ~ro;
        csr_illegal = csr_valid & (~hit | (ro & wr_req));
        csr_rdata   = csr_valid ? rd : 32'd0;
    end

    // next state: a CSR write to a counter half wins over its increment
    always_comb begin
        for (int i = 0; i < NUM_APX; i++) begin
            apx_d[i] = (do_wr && apx_hit[i]) ? wval : apx_q[i];
        end
        inh_d  = (do_wr && inh_hit) ? (wval & INH_MASK) : inh_q;
        inc    = '0;
        inc[0] = ~inh_q[0];
        inc[1] = instr_retire & ~inh_q[2];
        for (int h = 0; h < NUM_HPM; h++) begin
            inc[2+h] = hpm_event[h] & ~inh_q[3+h];
        end
        for (int k = 0; k < NC; k++) begin
            if (do_wr && lo_hit[k]) begin
                cnt_d[k] = {cnt_q[k][63:32], wval};
            end else if (do_wr && hi_hit[k]) begin
                cnt_d[k] = {wval, cnt_q[k][31:0]};
            end else if (inc[k]) begin
                cnt_d[k] = cnt_q[k] + 64'd1;
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_APX; i++) apx_q[i] <= '0;
            for (int k = 0; k < NC; k++) cnt_q[k] <= '0;
            inh_q <= '0;
        end else begin
            for (int i = 0; i < NUM_APX; i++) apx_q[i] <= apx_d[i];
            for (int k = 0; k < NC; k++) cnt_q[k] <= cnt_d[k];
            inh_q <= inh_d;
        end
    end

    // flatten approximation CSRs for the arithmetic units
    always_comb begin
        for (int i = 0; i < NUM_APX; i++) begin
            apx_csr_flat[32*i +: 32] = apx_q[i];
        end
    end

endmodule

// File: tb/tb_csr_bank_param.sv
// tb_csr_bank_param: directed scoreboard bench for csr_bank_param.
// Build with or without CSR_USER_COUNTERS_EN to match the design.
module tb_csr_bank_param;

    localparam int NUM_APX = 3;
    localparam int NUM_HPM = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   csr_valid;
    logic [1:0]             csr_op;
    logic [11:0]            csr_index;
    logic [31:0]            csr_wdata;
    logic [31:0]            csr_rdata;
    logic                   csr_illegal;
    logic                   instr_retire;
    logic [NUM_HPM-1:0]     hpm_event;
    logic [32*NUM_APX-1:0]  apx_csr_flat;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    csr_bank_param #(
        .NUM_APX (NUM_APX),
        .APX_BASE(12'h800),
        .NUM_HPM (NUM_HPM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_valid   (csr_valid),
        .csr_op      (csr_op),
        .csr_index   (csr_index),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .instr_retire(instr_retire),
        .hpm_event   (hpm_event),
        .apx_csr_flat(apx_csr_flat)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] idx,
                         input logic [31:0] wd);
        @(negedge clk);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_index = idx;
        csr_wdata = wd;
    endtask

    task automatic acc(input logic [1:0] op, input logic [11:0] idx,
                       input logic [31:0] wd, input logic [31:0] erd,
                       input logic eil, input string tag);
        drive(op, idx, wd);
        push({tag, "_rd"}, erd);
        push({tag, "_il"}, {31'd0, eil});
        #1;
        pop_chk(csr_rdata);
        pop_chk({31'd0, csr_illegal});
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] idx,
                      input logic [31:0] wd, input logic eil, input string tag);
        drive(op, idx, wd);
        push({tag, "_il"}, {31'd0, eil});
        #1;
        pop_chk({31'd0, csr_illegal});
    endtask

    task automatic peek(input int i, input logic [31:0] ev, input string tag);
        @(negedge clk);
        csr_valid = 1'b0;
        csr_op    = 2'b00;
        push(tag, ev);
        push({tag, "_idle_rd"}, 32'd0);
        push({tag, "_idle_il"}, 32'd0);
        #1;
        pop_chk(apx_csr_flat[32*i +: 32]);
        pop_chk(csr_rdata);
        pop_chk({31'd0, csr_illegal});
    endtask

    initial begin
        reset        = 1'b1;
        csr_valid    = 1'b0;
        csr_op       = 2'b00;
        csr_index    = 12'h800;
        csr_wdata    = '0;
        instr_retire = 1'b0;
        hpm_event    = '0;
        #2;
        push("rst_flat", 32'd0);
        push("rst_rd", 32'd0);
        push("rst_il", 32'd0);
        pop_chk(32'(apx_csr_flat));
        pop_chk(csr_rdata);
        pop_chk({31'd0, csr_illegal});
        @(negedge clk);
        reset = 1'b0;

        acc(2'b00, 12'hB00, 0, 32'd1, 1'b0, "mcyc_start");
        acc(2'b00, 12'hB02, 0, 32'd0, 1'b0, "minst_rst");
        acc(2'b00, 12'hB03, 0, 32'd0, 1'b0, "hpm_rst");

        acc(2'b01, 12'h800, 32'hA5, 32'd0, 1'b0, "apx0_rw");
        peek(0, 32'hA5, "apx0_flat");
        acc(2'b01, 12'h801, 32'h0F, 32'd0, 1'b0, "apx1_rw");
        acc(2'b10, 12'h801, 32'hF0, 32'h0F, 1'b0, "apx1_rs");
        peek(1, 32'hFF, "apx1_flat_rs");
        acc(2'b11, 12'h801, 32'h0F, 32'hFF, 1'b0, "apx1_rc");
        acc(2'b00, 12'h801, 0, 32'hF0, 1'b0, "apx1_rd");
        acc(2'b10, 12'h801, 0, 32'hF0, 1'b0, "apx1_rs0");
        acc(2'b01, 12'h803, 32'h1, 32'd0, 1'b1, "apx_oob");
        peek(1, 32'hF0, "apx1_hold");

        wr(2'b01, 12'hB80, 32'd0, 1'b0, "mcych_w");
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, "mcyc_w");
        acc(2'b00, 12'hB00, 0, 32'hFFFF_FFFF, 1'b0, "mcyc_pre");
        acc(2'b00, 12'hB80, 0, 32'd1, 1'b0, "mcych_carry");
        acc(2'b00, 12'hB00, 0, 32'd1, 1'b0, "mcyc_wrap");
`ifdef CSR_USER_COUNTERS_EN
        acc(2'b10, 12'hC00, 0, 32'd2, 1'b0, "ucyc_rs0");
        acc(2'b01, 12'hC80, 32'd5, 32'd1, 1'b1, "ucych_wr");
        acc(2'b00, 12'hB80, 0, 32'd1, 1'b0, "mcych_keep");
`else
        acc(2'b10, 12'hC00, 0, 32'd0, 1'b1, "ucyc_unmap");
        acc(2'b00, 12'hC80, 0, 32'd0, 1'b1, "ucych_unmap");
`endif

        wr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, "all1_lo");
        wr(2'b01, 12'hB80, 32'hFFFF_FFFF, 1'b0, "all1_hi");
        acc(2'b00, 12'hB00, 0, 32'hFFFF_FFFF, 1'b0, "all1_rd");
        acc(2'b00, 12'hB80, 0, 32'd0, 1'b0, "wrap64_hi");
        acc(2'b00, 12'hB00, 0, 32'd1, 1'b0, "wrap64_lo");

        wr(2'b01, 12'hB00, 32'h10, 1'b0, "mcyc_set");
        wr(2'b01, 12'hB02, 32'h20, 1'b0, "minst_set");
        acc(2'b01, 12'h320, 32'h5, 32'd0, 1'b0, "inh_set");
        @(negedge clk);
        csr_valid    = 1'b0;
        instr_retire = 1'b1;
        hpm_event    = '1;
        repeat (10) @(negedge clk);
        instr_retire = 1'b0;
        hpm_event    = '0;
        acc(2'b00, 12'hB00, 0, 32'h12, 1'b0, "mcyc_frozen");
        acc(2'b00, 12'hB02, 0, 32'h20, 1'b0, "minst_frozen");
        acc(2'b00, 12'hB03, 0, 32'd10, 1'b0, "hpm3_count");
        acc(2'b00, 12'hB06, 0, 32'd10, 1'b0, "hpm6_count");
        acc(2'b00, 12'h320, 0, 32'h5, 1'b0, "inh_rd");
        acc(2'b01, 12'h320, 32'hFFFF_FFFF, 32'h5, 1'b0, "inh_all");
        acc(2'b00, 12'h320, 0, 32'h7D, 1'b0, "inh_mask");
        acc(2'b01, 12'h320, 32'd0, 32'h7D, 1'b0, "inh_clr");
        acc(2'b00, 12'hB00, 0, 32'h12, 1'b0, "mcyc_old_inh");
        acc(2'b00, 12'hB00, 0, 32'h13, 1'b0, "mcyc_resume");

        instr_retire = 1'b1;
        wr(2'b01, 12'hB02, 32'd100, 1'b0, "minst_w100");
        acc(2'b00, 12'hB02, 0, 32'd100, 1'b0, "minst_100");
        acc(2'b00, 12'hB02, 0, 32'd101, 1'b0, "minst_101");
        instr_retire = 1'b0;
        acc(2'b00, 12'hB02, 0, 32'd101, 1'b0, "minst_hold");

        acc(2'b01, 12'h7FF, 32'h1234, 32'd0, 1'b1, "unmap_rw");
        acc(2'b00, 12'h7FF, 0, 32'd0, 1'b1, "unmap_rd");
        peek(0, 32'hA5, "apx0_nochg");
        peek(1, 32'hF0, "apx1_nochg");

        wr(2'b01, 12'h802, 32'h33, 1'b0, "apx2_w");
        peek(2, 32'h33, "apx2_flat");
        drive(2'b01, 12'h802, 32'h55);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NUM_APX; i++) begin
            push($sformatf("rst_async_apx%0d", i), 32'd0);
            pop_chk(apx_csr_flat[32*i +: 32]);
        end
        @(negedge clk);
        csr_valid = 1'b0;
        reset     = 1'b0;
        acc(2'b00, 12'h802, 0, 32'd0, 1'b0, "apx2_discard");
        acc(2'b00, 12'hB02, 0, 32'd0, 1'b0, "minst_rst2");
        acc(2'b00, 12'hB03, 0, 32'd0, 1'b0, "hpm_rst2");
        acc(2'b00, 12'hB80, 0, 32'd0, 1'b0, "mcych_rst2");
        acc(2'b00, 12'h320, 0, 32'd0, 1'b0, "inh_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
